// File: rtl/pong_2p_if.sv
// pong_2p_if: video-timing inputs, player buttons and display/status outputs
// of the two-player pong core, bundled as one port.
//   master : drives counters, display enable and buttons; reads colour/status
//   slave  : the core side
//   counter_x/counter_y/in_display : pixel position and visible-area flag
//   btn_*                           : synchronised paddle and start buttons
//   vga_R/G/B                       : registered 1-bit colour
//   score_l/score_r/game_state/winner : status for segment/LED logic
interface pong_2p_if #(parameter int SCORE_W = 4);
  logic [9:0]         counter_x;
  logic [8:0]         counter_y;
  logic               in_display;
  logic               btn_l_up, btn_l_down, btn_r_up, btn_r_down, btn_start;
  logic               vga_R, vga_G, vga_B;
  logic [SCORE_W-1:0] score_l, score_r;
  logic [1:0]         game_state;
  logic               winner;

  modport master (
    output counter_x, counter_y, in_display,
    output btn_l_up, btn_l_down, btn_r_up, btn_r_down, btn_start,
    input  vga_R, vga_G, vga_B, score_l, score_r, game_state, winner
  );

  modport slave (
    input  counter_x, counter_y, in_display,
    input  btn_l_up, btn_l_down, btn_r_up, btn_r_down, btn_start,
    output vga_R, vga_G, vga_B, score_l, score_r, game_state, winner
  );
endinterface

// File: rtl/pong_2p_core.sv
// pong_2p_core: two-player pong. Game state advances once per frame on a
// registered tick taken in vertical blanking; rendering is a combinational
// object test followed by one register stage (1 clk pixel latency).
//   clk, rst_n : pixel clock, asynchronous active-low reset
//   bus        : pong_2p_if.slave (timing in, buttons in, RGB/score/state out)
module pong_2p_core #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int WALL         = 8,
  parameter int BALL_SIZE    = 16,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_STEP  = 2,
  parameter int BALL_SPEED   = 1,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9,
  parameter int SCORE_W      = 4,
  parameter int FRAME_LINE   = 500
) (
  input logic      clk,
  input logic      rst_n,
  pong_2p_if.slave bus
);
  typedef logic signed [10:0] s11_t;
  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;

  localparam int   CNT_W   = $clog2(SERVE_FRAMES + 1);
  localparam s11_t K_WALL  = s11_t'(WALL);
  localparam s11_t K_BALL  = s11_t'(BALL_SIZE);
  localparam s11_t K_PW    = s11_t'(PADDLE_W);
  localparam s11_t K_PH    = s11_t'(PADDLE_H);
  localparam s11_t K_STEP  = s11_t'(PADDLE_STEP);
  localparam s11_t K_SPD   = s11_t'(BALL_SPEED);
  localparam s11_t P_MIN   = s11_t'(WALL);
  localparam s11_t P_MAX   = s11_t'(V_RES - WALL - PADDLE_H);
  localparam s11_t Y_FLOOR = s11_t'(V_RES - WALL);
  localparam s11_t X_LEFT  = s11_t'(WALL + PADDLE_W);          // left paddle face
  localparam s11_t X_RIGHT = s11_t'(H_RES - WALL - PADDLE_W);  // right paddle face
  localparam logic [9:0] BX0 = 10'(H_RES / 2 - BALL_SIZE / 2);
  localparam logic [9:0] BY0 = 10'(V_RES / 2 - BALL_SIZE / 2);
  localparam logic [9:0] P0  = 10'((V_RES - PADDLE_H) / 2);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(SERVE_FRAMES);
  localparam logic [SCORE_W-1:0] WIN_M1   = SCORE_W'(WIN_SCORE - 1);

  state_t             state;
  logic               frame_tick;
  logic [9:0]         ball_x, ball_y, paddle_l, paddle_r;
  logic               dir_x, dir_y;   // dir_x 1 = leftward, dir_y 1 = upward
  logic [CNT_W-1:0]   serve_cnt;
  logic [SCORE_W-1:0] score_l, score_r;
  logic               winner;
  logic [2:0]         rgb;

  function automatic s11_t paddle_move(input s11_t p, input logic up, input logic dn);
    s11_t q;
    q = p;
    if (up && !dn)      q = p - K_STEP;
    else if (dn && !up) q = p + K_STEP;
    if (q < P_MIN)      q = P_MIN;
    else if (q > P_MAX) q = P_MAX;
    return q;
  endfunction

  s11_t bx, by, pl, pr, nx, ny, cx, cy, pl_n, pr_n, bx_n, by_n;
  logic ov_l, ov_r, dx_n, dy_n, pt_l, pt_r, obj;

  always_comb begin
    bx   = s11_t'({1'b0, ball_x});
    by   = s11_t'({1'b0, ball_y});
    pl   = s11_t'({1'b0, paddle_l});
    pr   = s11_t'({1'b0, paddle_r});
    cx   = s11_t'({1'b0, bus.counter_x});
    cy   = s11_t'({2'b0, bus.counter_y});
    pl_n = paddle_move(pl, bus.btn_l_up, bus.btn_l_down);
    pr_n = paddle_move(pr, bus.btn_r_up, bus.btn_r_down);
    nx   = dir_x ? bx - K_SPD : bx + K_SPD;
    ny   = dir_y ? by - K_SPD : by + K_SPD;
    // paddle overlap is judged on the pre-move ball row
    ov_l = (by + K_BALL > pl) && (by < pl + K_PH);
    ov_r = (by + K_BALL > pr) && (by < pr + K_PH);

    by_n = ny;
    dy_n = dir_y;
    if (ny < K_WALL) begin
      by_n = K_WALL;
      dy_n = 1'b0;
    end else if (ny + K_BALL > Y_FLOOR) begin
      by_n = Y_FLOOR - K_BALL;
      dy_n = 1'b1;
    end

    bx_n = nx;
    dx_n = dir_x;
    pt_l = 1'b0;
    pt_r = 1'b0;
    if (dir_x && nx < X_LEFT) begin
      if (ov_l) begin bx_n = X_LEFT; dx_n = 1'b0; end
      else pt_r = 1'b1;
    end else if (!dir_x && nx + K_BALL > X_RIGHT) begin
      if (ov_r) begin bx_n = X_RIGHT - K_BALL; dx_n = 1'b1; end
      else pt_l = 1'b1;
    end

    obj = (cy < K_WALL) || (cy >= Y_FLOOR)
       || (cx >= K_WALL  && cx < X_LEFT         && cy >= pl && cy < pl + K_PH)
       || (cx >= X_RIGHT && cx < X_RIGHT + K_PW && cy >= pr && cy < pr + K_PH)
       || (cx >= bx      && cx < bx + K_BALL    && cy >= by && cy < by + K_BALL);
  end

  // sign bits of clamped results are always 0
  logic unused_msb;
  assign unused_msb = ^{pl_n[10], pr_n[10], bx_n[10], by_n[10]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      frame_tick <= 1'b0;
      ball_x     <= BX0;
      ball_y     <= BY0;
      paddle_l   <= P0;
      paddle_r   <= P0;
      dir_x      <= 1'b0;
      dir_y      <= 1'b0;
      serve_cnt  <= '0;
      score_l    <= '0;
      score_r    <= '0;
      winner     <= 1'b0;
    end else begin
      frame_tick <= (bus.counter_y == 9'(FRAME_LINE)) && (bus.counter_x == 10'd0);
      if (frame_tick) begin
        if (state != OVER) begin
          paddle_l <= pl_n[9:0];
          paddle_r <= pr_n[9:0];
        end
        case (state)
          IDLE: begin
            ball_x <= BX0;
            ball_y <= BY0;
            if (bus.btn_start) begin
              state     <= SERVE;
              serve_cnt <= CNT_LOAD;
            end
          end
          SERVE: begin
            ball_x <= BX0;
            ball_y <= BY0;
            if (serve_cnt <= CNT_W'(1)) begin
              serve_cnt <= '0;
              state     <= PLAY;
            end else begin
              serve_cnt <= serve_cnt - 1'b1;
            end
          end
          PLAY: begin
            if (pt_l || pt_r) begin
              // ball recentred, served toward the player who lost the point
              ball_x    <= BX0;
              ball_y    <= BY0;
              dir_x     <= pt_r;
              serve_cnt <= CNT_LOAD;
              state     <= SERVE;
              if (pt_r) begin
                score_r <= score_r + 1'b1;
                if (score_r == WIN_M1) begin state <= OVER; winner <= 1'b1; end
              end else begin
                score_l <= score_l + 1'b1;
                if (score_l == WIN_M1) begin state <= OVER; winner <= 1'b0; end
              end
            end else begin
              ball_x <= bx_n[9:0];
              ball_y <= by_n[9:0];
              dir_x  <= dx_n;
              dir_y  <= dy_n;
            end
          end
          OVER: begin
            if (bus.btn_start) begin
              score_l   <= '0;
              score_r   <= '0;
              ball_x    <= BX0;
              ball_y    <= BY0;
              paddle_l  <= P0;
              paddle_r  <= P0;
              dir_x     <= 1'b0;
              serve_cnt <= CNT_LOAD;
              state     <= SERVE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                rgb <= 3'b000;
    else if (!bus.in_display)  rgb <= 3'b000;
    else if (obj)              rgb <= 3'b111;
    else if (state == OVER && (bus.counter_x[3] ^ bus.counter_y[3]))
                               rgb <= 3'b100;
    else                       rgb <= 3'b000;
  end

  assign bus.vga_R      = rgb[2];
  assign bus.vga_G      = rgb[1];
  assign bus.vga_B      = rgb[0];
  assign bus.score_l    = score_l;
  assign bus.score_r    = score_r;
  assign bus.game_state = state;
  assign bus.winner     = winner;
endmodule

// File: tb/tb_pong_2p_core.sv
// tb_pong_2p_core: directed game sequence for pong_2p_core. Expected values
// are queued before each step and popped against the DUT after it.
module tb_pong_2p_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pong_2p_if bus();
  pong_2p_core dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { string tag; int exp; } sb_t;
  sb_t sbq[$];
  int total = 0;
  int bad = 0;

  task automatic push(input string tag, input int exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    sb_t e;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $error("FAIL sb_empty: observed %0d with nothing expected", obs);
      return;
    end
    e = sbq.pop_front();
    assert (obs === 32'(e.exp)) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
    end
  endtask

  function automatic logic [2:0] rgb_now();
    return {bus.vga_R, bus.vga_G, bus.vga_B};
  endfunction

  // one frame tick: a single cycle at (0, FRAME_LINE), then leave it
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_display = 1'b0;
      bus.counter_y  = 9'd500;
      bus.counter_x  = 10'd0;
      @(negedge clk);
      bus.counter_x  = 10'd1;
      @(negedge clk);
    end
  endtask

  task automatic pixel(input int x, input int y, output logic [2:0] c);
    @(negedge clk);
    bus.counter_x  = 10'(x);
    bus.counter_y  = 9'(y);
    bus.in_display = 1'b1;
    @(negedge clk);
    c = rgb_now();
    bus.in_display = 1'b0;
    bus.counter_x  = 10'd1;
    bus.counter_y  = 9'd500;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] c;
    bus.counter_x = 10'd1; bus.counter_y = 9'd500; bus.in_display = 1'b0;
    bus.btn_l_up = 0; bus.btn_l_down = 0; bus.btn_r_up = 0; bus.btn_r_down = 0;
    bus.btn_start = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset state after 3 idle frames
    push("idle_state", 0); push("idle_bx", 312); push("idle_by", 232);
    push("idle_pl", 208); push("idle_pr", 208); push("idle_rgb", 0);
    tick(3);
    pop_check(bus.game_state); pop_check(dut.ball_x); pop_check(dut.ball_y);
    pop_check(dut.paddle_l); pop_check(dut.paddle_r); pop_check(rgb_now());

    // paddle clamps and button conflicts
    push("pl_top", 8);
    bus.btn_l_up = 1; tick(100); pop_check(dut.paddle_l);
    push("pl_top_hold", 8);
    tick(100); pop_check(dut.paddle_l);
    push("pl_both", 8);
    bus.btn_l_down = 1; tick(5); pop_check(dut.paddle_l);
    bus.btn_l_up = 0; bus.btn_l_down = 0;
    push("pr_bottom", 408);
    bus.btn_r_down = 1; tick(200); pop_check(dut.paddle_r);
    bus.btn_r_down = 0;
    push("pl_400", 400); push("pr_400", 400); push("idle_still", 0);
    bus.btn_l_down = 1; tick(196); bus.btn_l_down = 0;
    bus.btn_r_up = 1; tick(4); bus.btn_r_up = 0;
    pop_check(dut.paddle_l); pop_check(dut.paddle_r); pop_check(bus.game_state);

    // start and serve timing
    push("start_serve", 1);
    bus.btn_start = 1; tick(1); bus.btn_start = 0;
    pop_check(bus.game_state);
    push("serve_59", 1);
    tick(59); pop_check(bus.game_state);
    push("serve_60", 2); push("serve_bx", 312);
    tick(1); pop_check(bus.game_state); pop_check(dut.ball_x);
    push("play1_bx", 313); push("play1_by", 233);
    tick(1); pop_check(dut.ball_x); pop_check(dut.ball_y);

    // bottom wall, right paddle bounce, top wall, left miss
    push("floor_by", 456); push("floor_dy", 1); push("floor_bx", 537);
    tick(224); pop_check(dut.ball_y); pop_check(dut.dir_y); pop_check(dut.ball_x);
    push("pre_r_bx", 608); push("pre_r_by", 385);
    tick(71); pop_check(dut.ball_x); pop_check(dut.ball_y);
    push("rhit_bx", 608); push("rhit_by", 384); push("rhit_dx", 1); push("rhit_sl", 0);
    tick(1); pop_check(dut.ball_x); pop_check(dut.ball_y); pop_check(dut.dir_x);
    pop_check(bus.score_l);
    push("top_by", 8); push("top_dy", 0); push("top_bx", 231);
    tick(377); pop_check(dut.ball_y); pop_check(dut.dir_y); pop_check(dut.ball_x);
    push("pre_l_bx", 16); push("pre_l_by", 223);
    tick(215); pop_check(dut.ball_x); pop_check(dut.ball_y);
    push("miss_sr", 1); push("miss_sl", 0); push("miss_bx", 312); push("miss_by", 232);
    push("miss_dx", 1); push("miss_dy", 0); push("miss_state", 1);
    tick(1);
    pop_check(bus.score_r); pop_check(bus.score_l); pop_check(dut.ball_x);
    pop_check(dut.ball_y); pop_check(dut.dir_x); pop_check(dut.dir_y);
    pop_check(bus.game_state);

    // leftward serve hits the left paddle
    push("reserve_play", 2);
    tick(60); pop_check(bus.game_state);
    push("lhit_bx", 16); push("lhit_by", 384); push("lhit_dx", 0); push("lhit_sr", 1);
    push("lhit_sl", 0);
    tick(297);
    pop_check(dut.ball_x); pop_check(dut.ball_y); pop_check(dut.dir_x);
    pop_check(bus.score_r); pop_check(bus.score_l);
    push("move_bx", 21); push("move_by", 379);
    tick(5); pop_check(dut.ball_x); pop_check(dut.ball_y);

    // rendering in PLAY
    push("pix_lpad", 7); pixel(10, 420, c); pop_check(c);
    push("pix_bg", 0);   pixel(300, 200, c); pop_check(c);
    push("pix_ball", 7); pixel(25, 385, c); pop_check(c);

    // asynchronous reset mid-PLAY
    @(negedge clk);
    bus.counter_x = 10'd100; bus.counter_y = 9'd2; bus.in_display = 1'b1;
    push("pix_wall", 7);
    @(negedge clk); pop_check(rgb_now());
    #2 rst_n = 1'b0;
    push("arst_state", 0); push("arst_sr", 0); push("arst_rgb", 0); push("arst_win", 0);
    push("arst_bx", 312); push("arst_by", 232); push("arst_pl", 208); push("arst_dx", 0);
    #1;
    pop_check(bus.game_state); pop_check(bus.score_r); pop_check(rgb_now());
    pop_check(bus.winner); pop_check(dut.ball_x); pop_check(dut.ball_y);
    pop_check(dut.paddle_l); pop_check(dut.dir_x);
    @(negedge clk);
    bus.in_display = 1'b0; bus.counter_x = 10'd1; bus.counter_y = 9'd500;
    @(negedge clk);
    rst_n = 1'b1;

    // right player runs the match to WIN_SCORE
    push("g_pl", 8); push("g_pr", 400);
    bus.btn_l_up = 1; bus.btn_r_down = 1; tick(96); bus.btn_r_down = 0;
    tick(4); bus.btn_l_up = 0;
    pop_check(dut.paddle_l); pop_check(dut.paddle_r);
    bus.btn_start = 1; tick(1); bus.btn_start = 0;
    push("g_play", 2);
    tick(60); pop_check(bus.game_state);
    push("g_pt1", 1); push("g_pt1_state", 1);
    tick(890); pop_check(bus.score_r); pop_check(bus.game_state);
    for (int n = 2; n <= 9; n++) begin
      push($sformatf("g_pt%0d", n), n);
      push($sformatf("g_pt%0d_state", n), (n == 9) ? 3 : 1);
      tick(357);
      pop_check(bus.score_r); pop_check(bus.game_state);
    end
    push("over_win", 1); push("over_sl", 0);
    pop_check(bus.winner); pop_check(bus.score_l);

    // OVER: frozen ball and paddles, checkerboard background
    push("over_bx", 312); push("over_by", 232); push("over_pl", 8); push("over_state", 3);
    bus.btn_l_down = 1; tick(3); bus.btn_l_down = 0;
    pop_check(dut.ball_x); pop_check(dut.ball_y); pop_check(dut.paddle_l);
    pop_check(bus.game_state);
    push("chk_red", 4);    pixel(100, 200, c); pop_check(c);
    push("chk_black", 0);  pixel(96, 192, c);  pop_check(c);
    push("chk_red2", 4);   pixel(104, 192, c); pop_check(c);
    push("over_ball", 7);  pixel(320, 240, c); pop_check(c);
    push("over_nodisp", 0);
    @(negedge clk); bus.counter_x = 10'd100; bus.counter_y = 9'd200; bus.in_display = 1'b0;
    @(negedge clk); pop_check(rgb_now());

    // restart from OVER
    push("rs_state", 1); push("rs_sr", 0); push("rs_sl", 0); push("rs_pl", 208);
    push("rs_pr", 208); push("rs_bx", 312); push("rs_dx", 0);
    bus.btn_start = 1; tick(1); bus.btn_start = 0;
    pop_check(bus.game_state); pop_check(bus.score_r); pop_check(bus.score_l);
    pop_check(dut.paddle_l); pop_check(dut.paddle_r); pop_check(dut.ball_x);
    pop_check(dut.dir_x);

    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_leftover: %0d expectations never checked, expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
